// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: FSM states,
// ALU opcodes, status byte bit positions and the command frame length.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        WAIT     = 2'd1,
        SEND_RES = 2'd2,
        SEND_STS = 2'd3
    } seqState_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOTA = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7
    } aluOp_t;

    localparam logic [3:0] OP_LEGAL_MAX = 4'd7;

    localparam int ST_Z   = 0;
    localparam int ST_C   = 1;
    localparam int ST_N   = 2;
    localparam int ST_V   = 3;
    localparam int ST_TMO = 4;
    localparam int ST_ILL = 5;
    localparam int ST_OVR = 6;

    localparam int FRAME_NIBBLES = 5;

    // Opcodes above OP_LEGAL_MAX are rejected without involving the ALU.
    function automatic logic isLegalOp(input logic [3:0] op);
        return (op <= OP_LEGAL_MAX);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Bundle of the pin-side nibble bus, the ALU req/ack port and the
// valid/ready result port. master = sequencer side, slave = environment.
interface alu_cmd_sequencer_if;

    logic [3:0] nib_in;
    logic       nib_valid;
    logic       busy;
    logic [3:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_req;
    logic       alu_ack;
    logic [7:0] alu_result;
    logic [3:0] alu_flags;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  nib_in, nib_valid, alu_ack, alu_result, alu_flags, out_ready,
        output busy, alu_op, alu_a, alu_b, alu_req, out_data, out_valid
    );

    modport slave (
        output nib_in, nib_valid, alu_ack, alu_result, alu_flags, out_ready,
        input  busy, alu_op, alu_a, alu_b, alu_req, out_data, out_valid
    );

endinterface

// File: rtl/alu_seq_frame_asm.sv
// Frame assembler: collects five nibbles into opcode, A and B registers.
// The counter wraps on the last nibble so the next frame starts cleanly;
// i_clear forces it back to nibble 0 when a frame is fully retired.
module alu_seq_frame_asm
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_nibValid,
    input  logic [3:0] i_nib,
    output logic [3:0] o_op,
    output logic [7:0] o_a,
    output logic [7:0] o_b,
    output logic       o_frameDone
);

    localparam logic [2:0] LAST_IDX = 3'(FRAME_NIBBLES - 1);

    logic [2:0] r_nibCnt;
    logic [3:0] r_op;
    logic [7:0] r_a;
    logic [7:0] r_b;

    assign o_frameDone = i_nibValid && (r_nibCnt == LAST_IDX);
    assign o_op        = r_op;
    assign o_a         = r_a;
    assign o_b         = r_b;

    // Steer each accepted nibble into its field and advance the position.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_nibCnt <= 3'd0;
            r_op     <= 4'd0;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
        end else if (i_clear) begin
            r_nibCnt <= 3'd0;
        end else if (i_nibValid) begin
            case (r_nibCnt)
                3'd0:    r_op     <= i_nib;
                3'd1:    r_a[7:4] <= i_nib;
                3'd2:    r_a[3:0] <= i_nib;
                3'd3:    r_b[7:4] <= i_nib;
                default: r_b[3:0] <= i_nib;
            endcase
            r_nibCnt <= o_frameDone ? 3'd0 : (r_nibCnt + 3'd1);
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: turns a 5-nibble command frame into a full 8-bit
// ALU request, waits for the ALU with a timeout, then returns a result
// byte followed by a status byte over a valid/ready port.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_cmd_sequencer_if.master  bus
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seqState_t        r_state;
    logic [CNT_W-1:0] r_tmoCnt;
    logic [3:0]       r_flags;
    logic             r_timeout;
    logic             r_illegal;
    logic             r_overrun;
    logic             r_aluReq;
    logic             r_outValid;
    logic [7:0]       r_outData;
    logic             r_busy;

    logic             w_nibAccept;
    logic             w_newOvr;
    logic             w_accept;
    logic             w_clear;
    logic             w_frameDone;
    logic [3:0]       w_op;
    logic [7:0]       w_a;
    logic [7:0]       w_b;
    logic [7:0]       w_status;

    assign w_nibAccept = bus.nib_valid && (r_state == LOAD);
    assign w_newOvr    = bus.nib_valid && (r_state != LOAD);
    assign w_accept    = r_outValid && bus.out_ready;
    assign w_clear     = (r_state == SEND_STS) && w_accept;

    // A nibble dropped in the very cycle the status byte is latched is
    // still reported in that byte.
    always_comb begin
        w_status         = 8'h00;
        w_status[ST_V:ST_Z] = r_flags;
        w_status[ST_TMO] = r_timeout;
        w_status[ST_ILL] = r_illegal;
        w_status[ST_OVR] = r_overrun || w_newOvr;
    end

    alu_seq_frame_asm u_frameAsm (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_nibValid  (w_nibAccept),
        .i_nib       (bus.nib_in),
        .o_op        (w_op),
        .o_a         (w_a),
        .o_b         (w_b),
        .o_frameDone (w_frameDone)
    );

    // Main sequencer: request, timeout, result/status delivery and the
    // sticky overrun flag, with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_tmoCnt   <= '0;
            r_flags    <= 4'd0;
            r_timeout  <= 1'b0;
            r_illegal  <= 1'b0;
            r_overrun  <= 1'b0;
            r_aluReq   <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            if (w_clear) begin
                r_overrun <= w_newOvr;
            end else if (w_newOvr) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                LOAD: begin
                    if (w_frameDone) begin
                        r_busy <= 1'b1;
                        if (isLegalOp(w_op)) begin
                            r_state  <= WAIT;
                            r_aluReq <= 1'b1;
                            r_tmoCnt <= '0;
                        end else begin
                            r_state    <= SEND_RES;
                            r_flags    <= 4'd0;
                            r_illegal  <= 1'b1;
                            r_outValid <= 1'b1;
                            r_outData  <= 8'h00;
                        end
                    end
                end
                WAIT: begin
                    if (bus.alu_ack) begin
                        r_state    <= SEND_RES;
                        r_flags    <= bus.alu_flags;
                        r_aluReq   <= 1'b0;
                        r_outValid <= 1'b1;
                        r_outData  <= bus.alu_result;
                    end else if (r_tmoCnt == TMO_LAST) begin
                        r_state    <= SEND_RES;
                        r_flags    <= 4'd0;
                        r_timeout  <= 1'b1;
                        r_aluReq   <= 1'b0;
                        r_outValid <= 1'b1;
                        r_outData  <= 8'hFF;
                    end else begin
                        r_tmoCnt <= r_tmoCnt + 1'b1;
                    end
                end
                SEND_RES: begin
                    if (w_accept) begin
                        r_state   <= SEND_STS;
                        r_outData <= w_status;
                    end
                end
                SEND_STS: begin
                    if (w_accept) begin
                        r_state    <= LOAD;
                        r_outValid <= 1'b0;
                        r_outData  <= 8'h00;
                        r_busy     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_illegal  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.alu_op    = w_op;
    assign bus.alu_a     = w_a;
    assign bus.alu_b     = w_b;
    assign bus.alu_req   = r_aluReq;
    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed frames from the test
// plan plus randomized frames, checked by a scoreboard-driven monitor.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int TMO  = 15;
    localparam int HALF = 5;

    logic clk = 1'b0;
    logic rst;

    always #HALF clk = ~clk;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks = 0;
    int         fails  = 0;
    logic [7:0] expQ[$];
    string      nameQ[$];

    int         ackDelay    = 1000;
    int         stallCycles = 0;
    int         stallEpoch  = 0;
    bit         randReady   = 1'b0;
    int         strayReqs   = 0;
    int         reqHighCnt  = 0;
    logic [3:0] reqOp       = 4'd0;
    logic [7:0] reqA        = 8'd0;
    logic [7:0] reqB        = 8'd0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural ALU: returns {V,N,C,Z,result}.
    function automatic logic [11:0] aluModel(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       v;
        w = 9'd0; r = 8'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd7: begin r = {1'b0, a[7:1]}; c = a[0]; end
            default: r = 8'd0;
        endcase
        return {v, r[7], c, (r == 8'd0), r};
    endfunction

    // ALU responder: acks ackDelay cycles into the request, or injects a stray ack.
    initial begin
        int reqIdx;
        int strayDone;
        logic [11:0] m;
        reqIdx = 0;
        strayDone = 0;
        bus.alu_ack = 1'b0;
        bus.alu_result = 8'd0;
        bus.alu_flags = 4'd0;
        forever begin
            @(negedge clk);
            bus.alu_ack = 1'b0;
            if (strayDone != strayReqs) begin
                bus.alu_ack = 1'b1;
                bus.alu_result = 8'h5A;
                bus.alu_flags = 4'hF;
                strayDone++;
            end else if (bus.alu_req) begin
                if (reqIdx == 0) begin
                    reqOp = bus.alu_op;
                    reqA  = bus.alu_a;
                    reqB  = bus.alu_b;
                end
                if (reqIdx == ackDelay) begin
                    m = aluModel(bus.alu_op, bus.alu_a, bus.alu_b);
                    bus.alu_result = m[7:0];
                    bus.alu_flags  = m[11:8];
                    bus.alu_ack    = 1'b1;
                end
                reqIdx++;
                reqHighCnt++;
            end else begin
                reqIdx = 0;
            end
        end
    end

    // Consumer: optional forced stall on the first valid byte, else random or always ready.
    initial begin
        int left;
        int seen;
        left = 0;
        seen = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (seen != stallEpoch) begin
                seen = stallEpoch;
                left = stallCycles;
            end
            if (bus.out_valid && left > 0) begin
                bus.out_ready = 1'b0;
                left--;
            end else if (randReady) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted byte and checks hold-stability.
    initial begin
        logic       pv;
        logic       pr;
        logic [7:0] pd;
        logic [7:0] e;
        string      nm;
        pv = 1'b0; pr = 1'b0; pd = 8'd0;
        forever begin
            @(negedge clk);
            #(HALF - 1);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("hold_data", 32'(bus.out_data), 32'(pd));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        fails++;
                        $display("[TB] FAIL unexpected_output: got 0x%0h, expected no output", bus.out_data);
                    end else begin
                        e  = expQ.pop_front();
                        nm = nameQ.pop_front();
                        checkOutput(nm, 32'(bus.out_data), 32'(e));
                    end
                end
                pv = bus.out_valid;
                pr = bus.out_ready;
                pd = bus.out_data;
            end
        end
    end

    task automatic sendNibbles(input logic [19:0] frame, input int count, input int maxGap);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, maxGap)) begin
                @(negedge clk);
                bus.nib_valid = 1'b0;
            end
            @(negedge clk);
            bus.nib_valid = 1'b1;
            bus.nib_in    = frame[(4 - i) * 4 +: 4];
        end
    endtask

    // Issue one frame, queue its expected bytes, and check request behaviour.
    task automatic applyStimulus(input logic [19:0] frame, input int delay, input int stall,
                                 input bit ovr, input int maxGap);
        logic [3:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  res;
        logic [7:0]  sts;
        logic [11:0] m;
        int          reqLen;
        int          base;
        bit          done;
        op = frame[19:16];
        a  = frame[15:8];
        b  = frame[7:0];
        if (op > 4'd7) begin
            res = 8'h00; sts = 8'h20; reqLen = 0;
        end else if (delay >= TMO) begin
            res = 8'hFF; sts = 8'h10; reqLen = TMO;
        end else begin
            m = aluModel(op, a, b);
            res = m[7:0]; sts = {4'h0, m[11:8]}; reqLen = delay + 1;
        end
        if (ovr) sts = sts | 8'h40;
        expQ.push_back(res);
        nameQ.push_back("result_byte");
        expQ.push_back(sts);
        nameQ.push_back("status_byte");
        ackDelay    = delay;
        stallCycles = stall;
        stallEpoch++;
        base = reqHighCnt;
        sendNibbles(frame, FRAME_NIBBLES, maxGap);
        @(negedge clk);
        bus.nib_valid = ovr;
        bus.nib_in    = 4'($urandom);
        if (ovr) begin
            @(negedge clk);
            bus.nib_valid = 1'b0;
        end
        done = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!bus.busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++;
            fails++;
            $display("[TB] FAIL frame_done_timeout: busy still high after 300 cycles, frame 0x%05h", frame);
        end
        checkOutput("req_cycles", 32'(reqHighCnt - base), 32'(reqLen));
        if (reqLen > 0) begin
            checkOutput("req_op", 32'(reqOp), 32'(op));
            checkOutput("req_a", 32'(reqA), 32'(a));
            checkOutput("req_b", 32'(reqB), 32'(b));
        end
        checkOutput("alu_a_reg", 32'(bus.alu_a), 32'(a));
        checkOutput("alu_b_reg", 32'(bus.alu_b), 32'(b));
        checkOutput("alu_op_reg", 32'(bus.alu_op), 32'(op));
        ackDelay = 1000;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        bus.nib_valid = 1'b0;
        bus.nib_in = 4'd0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_req", 32'(bus.alu_req), 32'd0);
        checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_op", 32'(bus.alu_op), 32'd0);
        checkOutput("rst_a", 32'(bus.alu_a), 32'd0);
        checkOutput("rst_b", 32'(bus.alu_b), 32'd0);
        rst = 1'b0;

        $display("[TB] directed frames");
        applyStimulus(20'h00102, 2, 0, 1'b0, 0);
        applyStimulus(20'h00102, 2, 3, 1'b0, 0);
        applyStimulus(20'h10507, 1000, 0, 1'b0, 0);
        repeat (2) @(negedge clk);
        strayReqs++;
        repeat (3) @(negedge clk);
        checkOutput("stray_busy", 32'(bus.busy), 32'd0);
        checkOutput("stray_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("stray_req", 32'(bus.alu_req), 32'd0);
        applyStimulus(20'h00102, 0, 0, 1'b0, 1);
        applyStimulus(20'hA1234, 0, 0, 1'b0, 0);
        applyStimulus(20'h00000, 1, 0, 1'b1, 0);
        applyStimulus(20'h00102, 1, 0, 1'b0, 0);
        applyStimulus(20'h68100, 14, 0, 1'b0, 0);
        applyStimulus(20'h68100, 15, 0, 1'b0, 0);

        $display("[TB] reset mid-frame");
        sendNibbles(20'h73C00, 3, 0);
        @(negedge clk);
        bus.nib_valid = 1'b0;
        checkOutput("partial_op", 32'(bus.alu_op), 32'h7);
        checkOutput("partial_a", 32'(bus.alu_a), 32'h3C);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_op", 32'(bus.alu_op), 32'd0);
        checkOutput("midrst_a", 32'(bus.alu_a), 32'd0);
        applyStimulus(20'h2F00F, 1, 0, 1'b0, 0);

        $display("[TB] reset during WAIT");
        ackDelay = 1000;
        sendNibbles(20'h01122, FRAME_NIBBLES, 0);
        @(negedge clk);
        bus.nib_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.alu_req) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("wait_req_seen", 32'(seen), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("waitrst_req", 32'(bus.alu_req), 32'd0);
        checkOutput("waitrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("waitrst_valid", 32'(bus.out_valid), 32'd0);
        rst = 1'b0;
        applyStimulus(20'h03C5A, 3, 0, 1'b0, 0);

        $display("[TB] randomized frames");
        randReady = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [3:0] op;
            logic [7:0] a;
            logic [7:0] b;
            int         d;
            int         r;
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            a  = 8'($urandom);
            b  = 8'($urandom);
            r  = $urandom_range(0, 9);
            if (r < 7)       d = $urandom_range(0, 4);
            else if (r == 7) d = 14;
            else if (r == 8) d = 15;
            else             d = 20;
            applyStimulus({op, a, b}, d, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), 2);
        end
        randReady = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Controller sitting between the narrow TinyTapeout pin bus and the 8-bit ALU datapath. It assembles a command frame (opcode, A, B) from 4-bit nibbles, issues it to the ALU over a req/ack handshake with a timeout, and captures the result and flags. It then returns a result byte and a status byte over a valid/ready output port. It gives the ALU full 8-bit operands despite only 4 usable input data pins.

Parameters:
TIMEOUT_CYCLES, 15, max cycles spent in WAIT without alu_ack before aborting (1..255)
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
nib_in  input  4  command nibble
nib_valid  input  1  nib_in valid this cycle
busy  output  1  high whenever state != LOAD
alu_op  output  4  opcode to ALU, registered
alu_a  output  8  operand A, registered
alu_b  output  8  operand B, registered
alu_req  output  1  request, level, held until ack or timeout
alu_ack  input  1  ALU result valid, sampled only in WAIT
alu_result  input  8  ALU result
alu_flags  input  4  {V,N,C,Z} from ALU
out_data  output  8  result byte, then status byte
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data

Behaviour:
- Reset: state=LOAD, nib_cnt=0, alu_op/alu_a/alu_b=0, alu_req=0, out_valid=0, out_data=0, busy=0, result/status/overrun regs=0. Reset wins over every other event in the same cycle.
- States: LOAD, WAIT, SEND_RES, SEND_STS.
- LOAD: each nib_valid stores nib_in by nib_cnt: 0->alu_op, 1->alu_a[7:4], 2->alu_a[3:0], 3->alu_b[7:4], 4->alu_b[3:0]. nib_cnt increments; no wait states between nibbles are required.
- On the 5th nibble (cycle t):
  - legal op (0..7): go to WAIT; alu_req=1 from t+1.
  - illegal op (8..15): result=0x00, illegal bit set, go to SEND_RES with no ALU request.
- WAIT:
  - alu_req=1 and operands held stable.
  - alu_ack=1 in any WAIT cycle (including the first): capture alu_result and alu_flags, alu_req=0 next cycle, go to SEND_RES. out_valid is high at the next cycle, so the best case is last nibble at t, ack at t+1, out_valid at t+2.
  - Timeout: the counter counts WAIT cycles. After TIMEOUT_CYCLES cycles without ack: result=0xFF, ALU flags=0, timeout bit set, alu_req=0, go to SEND_RES.
  - An ack arriving outside WAIT is ignored.
- SEND_RES: out_valid=1, out_data=result. On out_valid&out_ready go to SEND_STS. out_data must stay stable while out_valid&!out_ready.
- SEND_STS: out_data=status. Bits: [0]Z [1]C [2]N [3]V [4]timeout [5]illegal_op [6]overrun [7]0. On accept: go to LOAD, nib_cnt=0, clear timeout/illegal.
- Overrun: nib_valid while state!=LOAD drops the nibble and sets sticky overrun. Overrun is cleared on status-byte acceptance, unless a new overrun occurs in that same cycle, in which case it stays set.
- out_valid is 0 in LOAD and WAIT.
- No backpressure on nib_in; busy is advisory only.
- Reset mid-frame discards partial nibbles. Reset in WAIT drops alu_req on the next edge.

Decomposition:
- Package alu_seq_pkg:
  - state enum {LOAD, WAIT, SEND_RES, SEND_STS}
  - opcode enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOTA=5, SHL=6, SHR=7
  - OP_LEGAL_MAX=7
  - status bit index constants: ST_Z..ST_OVR
  - FRAME_NIBBLES=5
- Sub-module alu_seq_frame_asm: nibble counter plus op/A/B registers, frame_done pulse, clear input. The FSM, timeout and output mux stay in the top.

Test Plan:
1. Frame nibbles 0,0,1,0,2 (ADD, A=0x01, B=0x02); ALU model acks 2 cycles after req with 0x03/flags 0 -> alu_a=0x01, alu_b=0x02, alu_op=0; out 0x03 then 0x00; busy low after status accepted.
2. Same frame, out_ready held low 3 cycles in SEND_RES -> out_data stays 0x03 and out_valid stays 1; status 0x00 follows only after acceptance.
3. Frame 1,0,5,0,7 with ALU never acking -> alu_req high exactly 15 cycles; out 0xFF then 0x10; ack pulsed 2 cycles later is ignored and the next frame works normally.
4. Frame A,1,2,3,4 (opcode 0xA) -> alu_req never asserts; out 0x00 then 0x20.
5. nib_valid pulsed during WAIT of an ADD returning 0x00, Z=1 -> status 0x41; following clean frame -> status has bit6=0; nib_cnt unaffected by the dropped nibble.
6. rst asserted after 3 nibbles, then full frame 2,F,0,0,F (AND, A=0xF0, B=0x0F), ALU returns 0x00, Z=1 -> alu_a=0xF0, alu_b=0x0F, outputs 0x00 then 0x01; rst during WAIT -> alu_req=0 next cycle, state LOAD.
